vpu_tile_sequencer: RTL and testbench
=====================================

// Module: vpu_tile_sequencer
// PURPOSE
//  Run-time configurable tiling sequencer for the VPU matmul datapath (vpu_load / vpu_matmul).
//  Walks the output tiles C(i,j) = sum over k of A(i,k)*W(k,j) for M x K x N matrices given in tiles.
//  Issues handshaked row reads/writes and drives the load/compute/store strobes that feed the datapath.
//  Unlike the fixed single-tile controller, it supports multi-tile K accumulation, memory stalls and abort.
// PARAMETERS
//  TILE        4    tile edge; rows per tile load/store, one bus word per row
//  ADDR_WIDTH  16   memory word-address width
//  DIM_WIDTH   8    width of the tile-count config fields
//  COMP_CYC    10   compute cycles per k-step (3*TILE-2 for the systolic array)
// PORTS
//  clk          in   1           clock
//  reset        in   1           synchronous, active-high reset
//  start        in   1           pulse; accepted only in IDLE
//  abort        in   1           return to IDLE next cycle; done not pulsed
//  cfg_m/n/k    in   DIM_WIDTH   tile counts Mt, Nt, Kt; sampled at the accepted start
//  cfg_base_a/w/res in ADDR_WIDTH base word addresses; sampled at the accepted start
//  rd_req       out  1           read request; rd_addr/rd_sel held stable until rd_ack
//  rd_addr      out  ADDR_WIDTH  read address
//  rd_sel       out  1           0 = A row, 1 = W row
//  rd_ack       in   1           read data valid this cycle
//  load_a/load_w out 1           one-cycle strobe on each acked A/W row
//  clear_acc    out  1           one-cycle pulse before the first k-step of each output tile
//  compute      out  1           high for COMP_CYC cycles per k-step
//  wr_req/wr_addr out 1/ADDR_WIDTH result-row write request; address held until wr_ack
//  wr_ack       in   1           write accepted
//  store        out  1           one-cycle strobe on each acked result row
//  tile_i/j/k   out  DIM_WIDTH   current tile indices
//  busy, done, cfg_err out 1     done/cfg_err are one-cycle pulses
// BEHAVIOUR
//  Reset: state IDLE; every output and counter at 0.
//  FSM: IDLE -> CLEAR -> LOAD_A -> LOAD_W -> COMPUTE -> (next k: LOAD_A | last k: STORE) -> next (i,j) CLEAR | DONE -> IDLE.
//  Loop order: k innermost, then j, then i. CLEAR lasts one cycle and asserts clear_acc.
//  LOAD_A/LOAD_W/STORE each take TILE acked beats with row counter r = 0..TILE-1; no ack means stall.
//  Addresses: A = base_a + (i*TILE+r)*Kt + k; W = base_w + (k*TILE+r)*Nt + j; R = base_res + (i*TILE+r)*Nt + j.
//  All address arithmetic is modulo 2^ADDR_WIDTH and wraps silently.
//  Latency: the accepted start drives busy=1 and CLEAR next cycle; rd_req rises the following cycle.
//  done pulses in the cycle after the final wr_ack, busy falls with it.
//  Req/addr/sel may change only in the cycle after an ack; back-to-back acks give one beat per cycle.
//  Any of Mt/Nt/Kt == 0 at start: no traffic, cfg_err pulses next cycle, done stays 0, stays IDLE.
//  start while busy: ignored and config not resampled. abort overrides start and all acks in the same cycle.
//  reset mid-operation behaves like abort and also clears outputs; an outstanding req is dropped.
//  Ack while no req is raised: ignored.
// STRUCTURE
//  Shared package vpu_pkg: FSM state enum, TILE/COMP_CYC defaults, rd_sel encodings.
//  One sub-module, vpu_tile_addr: registered index-to-address computation.
//  Its multiplies by Kt/Nt become running stride adders, so the top stays counter + FSM only.
// TESTING
//  Mt=Nt=Kt=1, TILE=4, acks always high: rd addrs A 0..3, W base_w+0..3; 10 compute cycles; 4 writes; done.
//  Mt=1,Nt=2,Kt=2, base_a=0x100: A row r of k=1 at 0x100+2r+1; clear_acc exactly 2 times; 4 compute bursts.
//  Random rd_ack/wr_ack at 30%: addr/sel/req stable while stalled; beat count and address sequence unchanged.
//  cfg_k=0 with start: cfg_err pulse next cycle, no rd_req/wr_req, busy never set.
//  abort during STORE beat 2 (or reset in LOAD_W): IDLE next cycle, outputs 0, no done; a new start runs fully.
//  base_res=0xFFFE, Nt=1: write addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared types and defaults for the VPU tiling sequencer and its address unit.
package vpu_pkg;
  localparam int TILE_DEF     = 4;
  localparam int COMP_CYC_DEF = 10;

  localparam logic RD_SEL_A = 1'b0;
  localparam logic RD_SEL_W = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_A, S_LOAD_W, S_COMPUTE, S_STORE, S_DONE
  } state_t;

  typedef enum logic [1:0] {ADV_NONE, ADV_K, ADV_J, ADV_I} adv_t;

  typedef enum logic [1:0] {PTR_A, PTR_W, PTR_R} ptr_sel_t;
endpackage

// File: rtl/vpu_tile_addr.sv
// Tile address generator: row pointer plus running per-index bases, so the
// products by Kt/Nt reduce to stride additions.
module vpu_tile_addr import vpu_pkg::*; #(
  parameter int TILE       = TILE_DEF,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_init,
  input  logic [DIM_WIDTH-1:0]  i_cfg_n,
  input  logic [DIM_WIDTH-1:0]  i_cfg_k,
  input  logic [ADDR_WIDTH-1:0] i_base_a,
  input  logic [ADDR_WIDTH-1:0] i_base_w,
  input  logic [ADDR_WIDTH-1:0] i_base_res,
  input  adv_t                  i_adv,
  input  logic                  i_ptr_ld,
  input  logic                  i_ptr_step,
  input  ptr_sel_t              i_ptr_sel,
  output logic [ADDR_WIDTH-1:0] o_addr
);
  logic [ADDR_WIDTH-1:0] r_kt, r_nt, r_tk, r_tn, r_base_w;
  logic [ADDR_WIDTH-1:0] r_a_irow, r_a_tile, r_w_jcol, r_w_tile, r_r_irow, r_r_tile, r_ptr;
  logic [ADDR_WIDTH-1:0] w_a_irow, w_a_tile, w_w_jcol, w_w_tile, w_r_irow, w_r_tile, w_ptr_base;

  // Bases after this cycle's index advance; a pointer load sees the new tile at once.
  always_comb begin
    w_a_irow = r_a_irow;
    w_a_tile = r_a_tile;
    w_w_jcol = r_w_jcol;
    w_w_tile = r_w_tile;
    w_r_irow = r_r_irow;
    w_r_tile = r_r_tile;
    case (i_adv)
      ADV_K: begin
        w_a_tile = r_a_tile + ADDR_WIDTH'(1);
        w_w_tile = r_w_tile + r_tn;
      end
      ADV_J: begin
        w_a_tile = r_a_irow;
        w_w_jcol = r_w_jcol + ADDR_WIDTH'(1);
        w_w_tile = r_w_jcol + ADDR_WIDTH'(1);
        w_r_tile = r_r_tile + ADDR_WIDTH'(1);
      end
      ADV_I: begin
        w_a_irow = r_a_irow + r_tk;
        w_a_tile = r_a_irow + r_tk;
        w_w_jcol = r_base_w;
        w_w_tile = r_base_w;
        w_r_irow = r_r_irow + r_tn;
        w_r_tile = r_r_irow + r_tn;
      end
      default: ;
    endcase
    case (i_ptr_sel)
      PTR_A:   w_ptr_base = w_a_tile;
      PTR_W:   w_ptr_base = w_w_tile;
      PTR_R:   w_ptr_base = w_r_tile;
      default: w_ptr_base = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_kt     <= '0;
      r_nt     <= '0;
      r_tk     <= '0;
      r_tn     <= '0;
      r_base_w <= '0;
      r_a_irow <= '0;
      r_a_tile <= '0;
      r_w_jcol <= '0;
      r_w_tile <= '0;
      r_r_irow <= '0;
      r_r_tile <= '0;
      r_ptr    <= '0;
    end else if (i_init) begin
      r_kt     <= ADDR_WIDTH'(i_cfg_k);
      r_nt     <= ADDR_WIDTH'(i_cfg_n);
      r_tk     <= ADDR_WIDTH'(TILE) * ADDR_WIDTH'(i_cfg_k);
      r_tn     <= ADDR_WIDTH'(TILE) * ADDR_WIDTH'(i_cfg_n);
      r_base_w <= i_base_w;
      r_a_irow <= i_base_a;
      r_a_tile <= i_base_a;
      r_w_jcol <= i_base_w;
      r_w_tile <= i_base_w;
      r_r_irow <= i_base_res;
      r_r_tile <= i_base_res;
    end else begin
      r_a_irow <= w_a_irow;
      r_a_tile <= w_a_tile;
      r_w_jcol <= w_w_jcol;
      r_w_tile <= w_w_tile;
      r_r_irow <= w_r_irow;
      r_r_tile <= w_r_tile;
      if (i_ptr_ld)
        r_ptr <= w_ptr_base;
      else if (i_ptr_step)
        r_ptr <= r_ptr + ((i_ptr_sel == PTR_A) ? r_kt : r_nt);
    end
  end

  assign o_addr = r_ptr;
endmodule

// File: rtl/vpu_tile_sequencer.sv
// Tiling sequencer for the VPU matmul datapath: walks output tiles (k inner,
// then j, then i), handshakes row reads/writes and strobes load/compute/store.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for start; bad config pulses cfg_err
// S_CLEAR   | one-cycle clear_acc before a new output tile
// S_LOAD_A  | TILE acked A-row reads for (i,k)
// S_LOAD_W  | TILE acked W-row reads for (k,j)
// S_COMPUTE | COMP_CYC cycles of compute for one k-step
// S_STORE   | TILE acked result-row writes for (i,j)
// S_DONE    | one-cycle done pulse, busy already low
module vpu_tile_sequencer import vpu_pkg::*; #(
  parameter int TILE       = TILE_DEF,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8,
  parameter int COMP_CYC   = COMP_CYC_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [DIM_WIDTH-1:0]  i_cfg_m,
  input  logic [DIM_WIDTH-1:0]  i_cfg_n,
  input  logic [DIM_WIDTH-1:0]  i_cfg_k,
  input  logic [ADDR_WIDTH-1:0] i_cfg_base_a,
  input  logic [ADDR_WIDTH-1:0] i_cfg_base_w,
  input  logic [ADDR_WIDTH-1:0] i_cfg_base_res,
  output logic                  o_rd_req,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_rd_sel,
  input  logic                  i_rd_ack,
  output logic                  o_load_a,
  output logic                  o_load_w,
  output logic                  o_clear_acc,
  output logic                  o_compute,
  output logic                  o_wr_req,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  input  logic                  i_wr_ack,
  output logic                  o_store,
  output logic [DIM_WIDTH-1:0]  o_tile_i,
  output logic [DIM_WIDTH-1:0]  o_tile_j,
  output logic [DIM_WIDTH-1:0]  o_tile_k,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_cfg_err
);
  localparam int ROW_W = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int TMR_W = (COMP_CYC > 2) ? $clog2(COMP_CYC) : 1;

  state_t                r_state, w_state_nxt;
  logic [DIM_WIDTH-1:0]  r_mt, r_nt, r_kt, r_i, r_j, r_k;
  logic [ROW_W-1:0]      r_row;
  logic [TMR_W-1:0]      r_tmr;
  logic                  r_cfg_err;
  logic                  w_init, w_ptr_ld, w_ptr_step, w_row_inc, w_row_clr, w_tmr_ld;
  logic                  w_k_inc, w_j_inc, w_i_inc, w_ctr_clr, w_cfg_err;
  adv_t                  w_adv;
  ptr_sel_t              w_ptr_sel;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_row_last, w_k_last, w_j_last, w_i_last, w_cfg_ok;

  assign w_row_last = (r_row == ROW_W'(TILE - 1));
  assign w_k_last   = (r_k == r_kt - DIM_WIDTH'(1));
  assign w_j_last   = (r_j == r_nt - DIM_WIDTH'(1));
  assign w_i_last   = (r_i == r_mt - DIM_WIDTH'(1));
  assign w_cfg_ok   = (|i_cfg_m) & (|i_cfg_n) & (|i_cfg_k);

  vpu_tile_addr #(.TILE(TILE), .ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH)) u_addr (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_init     (w_init),
    .i_cfg_n    (i_cfg_n),
    .i_cfg_k    (i_cfg_k),
    .i_base_a   (i_cfg_base_a),
    .i_base_w   (i_cfg_base_w),
    .i_base_res (i_cfg_base_res),
    .i_adv      (w_adv),
    .i_ptr_ld   (w_ptr_ld),
    .i_ptr_step (w_ptr_step),
    .i_ptr_sel  (w_ptr_sel),
    .o_addr     (w_addr)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_adv       = ADV_NONE;
    w_ptr_ld    = 1'b0;
    w_ptr_step  = 1'b0;
    w_ptr_sel   = PTR_A;
    w_row_inc   = 1'b0;
    w_row_clr   = 1'b0;
    w_tmr_ld    = 1'b0;
    w_k_inc     = 1'b0;
    w_j_inc     = 1'b0;
    w_i_inc     = 1'b0;
    w_ctr_clr   = 1'b0;
    w_cfg_err   = 1'b0;
    o_rd_req    = 1'b0;
    o_rd_sel    = RD_SEL_A;
    o_wr_req    = 1'b0;
    o_load_a    = 1'b0;
    o_load_w    = 1'b0;
    o_clear_acc = 1'b0;
    o_compute   = 1'b0;
    o_store     = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        if (w_cfg_ok) begin
          w_init      = 1'b1;
          w_ctr_clr   = 1'b1;
          w_state_nxt = S_CLEAR;
        end else begin
          w_cfg_err = 1'b1;
        end
      end
      S_CLEAR: begin
        o_clear_acc = 1'b1;
        w_ptr_ld    = 1'b1;
        w_state_nxt = S_LOAD_A;
      end
      S_LOAD_A: begin
        o_rd_req = 1'b1;
        if (i_rd_ack) begin
          o_load_a = 1'b1;
          if (w_row_last) begin
            w_row_clr   = 1'b1;
            w_ptr_ld    = 1'b1;
            w_ptr_sel   = PTR_W;
            w_state_nxt = S_LOAD_W;
          end else begin
            w_row_inc  = 1'b1;
            w_ptr_step = 1'b1;
          end
        end
      end
      S_LOAD_W: begin
        o_rd_req  = 1'b1;
        o_rd_sel  = RD_SEL_W;
        w_ptr_sel = PTR_W;
        if (i_rd_ack) begin
          o_load_w = 1'b1;
          if (w_row_last) begin
            w_row_clr   = 1'b1;
            w_tmr_ld    = 1'b1;
            w_state_nxt = S_COMPUTE;
          end else begin
            w_row_inc  = 1'b1;
            w_ptr_step = 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        o_compute = 1'b1;
        if (r_tmr == '0) begin
          w_ptr_ld = 1'b1;
          if (w_k_last) begin
            w_ptr_sel   = PTR_R;
            w_state_nxt = S_STORE;
          end else begin
            w_k_inc     = 1'b1;
            w_adv       = ADV_K;
            w_state_nxt = S_LOAD_A;
          end
        end
      end
      S_STORE: begin
        o_wr_req  = 1'b1;
        w_ptr_sel = PTR_R;
        if (i_wr_ack) begin
          o_store = 1'b1;
          if (w_row_last) begin
            w_row_clr = 1'b1;
            if (!w_j_last) begin
              w_j_inc     = 1'b1;
              w_adv       = ADV_J;
              w_state_nxt = S_CLEAR;
            end else if (!w_i_last) begin
              w_i_inc     = 1'b1;
              w_adv       = ADV_I;
              w_state_nxt = S_CLEAR;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_row_inc  = 1'b1;
            w_ptr_step = 1'b1;
          end
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_ctr_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort wins over start and any ack seen this cycle.
    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_ctr_clr   = 1'b1;
      w_init      = 1'b0;
      w_cfg_err   = 1'b0;
      w_adv       = ADV_NONE;
      w_ptr_ld    = 1'b0;
      w_ptr_step  = 1'b0;
      w_row_inc   = 1'b0;
      w_row_clr   = 1'b0;
      w_tmr_ld    = 1'b0;
      w_k_inc     = 1'b0;
      w_j_inc     = 1'b0;
      w_i_inc     = 1'b0;
      o_load_a    = 1'b0;
      o_load_w    = 1'b0;
      o_store     = 1'b0;
    end
    o_rd_addr = o_rd_req ? w_addr : '0;
    o_wr_addr = o_wr_req ? w_addr : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mt      <= '0;
      r_nt      <= '0;
      r_kt      <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_row     <= '0;
      r_tmr     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_err;
      if (w_init) begin
        r_mt <= i_cfg_m;
        r_nt <= i_cfg_n;
        r_kt <= i_cfg_k;
      end
      if (w_ctr_clr) begin
        r_i   <= '0;
        r_j   <= '0;
        r_k   <= '0;
        r_row <= '0;
        r_tmr <= '0;
      end else begin
        if (w_row_clr)      r_row <= '0;
        else if (w_row_inc) r_row <= r_row + ROW_W'(1);
        if (w_tmr_ld)                              r_tmr <= TMR_W'(COMP_CYC - 1);
        else if (r_state == S_COMPUTE && r_tmr != '0) r_tmr <= r_tmr - TMR_W'(1);
        if (w_k_inc)                r_k <= r_k + DIM_WIDTH'(1);
        else if (w_j_inc || w_i_inc) r_k <= '0;
        if (w_j_inc)      r_j <= r_j + DIM_WIDTH'(1);
        else if (w_i_inc) r_j <= '0;
        if (w_i_inc) r_i <= r_i + DIM_WIDTH'(1);
      end
    end
  end

  assign o_tile_i  = r_i;
  assign o_tile_j  = r_j;
  assign o_tile_k  = r_k;
  assign o_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_cfg_err = r_cfg_err;
endmodule

// File: tb/tb_vpu_tile_sequencer.sv
// Directed bench for vpu_tile_sequencer: vector table of tile shapes plus
// hand sequences for cfg error, abort, reset and address wrap.
module tb_vpu_tile_sequencer;
  localparam int TILE = 4;

  logic        clk = 1'b0;
  logic        reset, start, abort, rd_ack, wr_ack;
  logic [7:0]  cfg_m, cfg_n, cfg_k;
  logic [15:0] cfg_base_a, cfg_base_w, cfg_base_res;
  logic        o_rd_req, o_rd_sel, o_load_a, o_load_w, o_clear_acc, o_compute;
  logic        o_wr_req, o_store, o_busy, o_done, o_cfg_err;
  logic [15:0] o_rd_addr, o_wr_addr;
  logic [7:0]  o_tile_i, o_tile_j, o_tile_k;
  logic        any_out;

  always #5 clk = ~clk;

  vpu_tile_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
    .i_cfg_m(cfg_m), .i_cfg_n(cfg_n), .i_cfg_k(cfg_k),
    .i_cfg_base_a(cfg_base_a), .i_cfg_base_w(cfg_base_w), .i_cfg_base_res(cfg_base_res),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .o_rd_sel(o_rd_sel), .i_rd_ack(rd_ack),
    .o_load_a(o_load_a), .o_load_w(o_load_w), .o_clear_acc(o_clear_acc), .o_compute(o_compute),
    .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .i_wr_ack(wr_ack), .o_store(o_store),
    .o_tile_i(o_tile_i), .o_tile_j(o_tile_j), .o_tile_k(o_tile_k),
    .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err)
  );

  assign any_out = o_busy | o_done | o_rd_req | o_wr_req | o_load_a | o_load_w | o_clear_acc |
                   o_compute | o_store | o_cfg_err | o_rd_sel | (|o_rd_addr) | (|o_wr_addr) |
                   (|o_tile_i) | (|o_tile_j) | (|o_tile_k);

  typedef struct {
    logic [7:0]  m, n, k;
    logic [15:0] ba, bw, br;
    int          pct;
    bit          poke;
    int          exp_rd, exp_wr, exp_clr, exp_comp;
  } vec_t;

  vec_t        vecs[6];
  int          n_checks = 0, n_pass = 0;
  logic [15:0] wr_log[4];
  int          wr_log_n;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    logic [15:0] q_rd[$];
    logic        q_sel[$];
    logic [15:0] q_wr[$];
    logic [15:0] ea, hold_a, hold_w;
    logic        es, hold_s;
    int n_rd, n_wr, n_clr, n_comp, n_burst, addr_err, stall_err, strobe_err;
    int cyc, first_clr, first_rd, last_wr_cyc, done_cyc;
    bit got_done, prev_comp, rd_stall, wr_stall;
    v = vecs[idx];
    n_rd = 0; n_wr = 0; n_clr = 0; n_comp = 0; n_burst = 0;
    addr_err = 0; stall_err = 0; strobe_err = 0;
    cyc = 0; first_clr = -1; first_rd = -1; last_wr_cyc = -100; done_cyc = -1;
    got_done = 0; prev_comp = 0; rd_stall = 0; wr_stall = 0;
    hold_a = '0; hold_w = '0; hold_s = 1'b0; wr_log_n = 0;
    for (int i = 0; i < int'(v.m); i++)
      for (int j = 0; j < int'(v.n); j++) begin
        for (int k = 0; k < int'(v.k); k++) begin
          for (int r = 0; r < TILE; r++) begin
            q_rd.push_back(16'(int'(v.ba) + (i*TILE + r)*int'(v.k) + k));
            q_sel.push_back(1'b0);
          end
          for (int r = 0; r < TILE; r++) begin
            q_rd.push_back(16'(int'(v.bw) + (k*TILE + r)*int'(v.n) + j));
            q_sel.push_back(1'b1);
          end
        end
        for (int r = 0; r < TILE; r++)
          q_wr.push_back(16'(int'(v.br) + (i*TILE + r)*int'(v.n) + j));
      end
    @(negedge clk);
    cfg_m = v.m; cfg_n = v.n; cfg_k = v.k;
    cfg_base_a = v.ba; cfg_base_w = v.bw; cfg_base_res = v.br;
    start = 1'b1;
    while (!got_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (v.poke && cyc >= 5 && cyc <= 8) begin
        start = 1'b1; cfg_m = v.m + 8'd2; cfg_base_a = v.ba + 16'd7;
      end
      rd_ack = ($urandom_range(99) < v.pct);
      wr_ack = ($urandom_range(99) < v.pct);
      #1;
      if (o_clear_acc) begin n_clr++; if (first_clr < 0) first_clr = cyc; end
      if (o_compute) begin n_comp++; if (!prev_comp) n_burst++; end
      prev_comp = o_compute;
      if (o_cfg_err || (!o_busy && !o_done) || (o_done && o_busy) || (o_rd_req && o_wr_req))
        strobe_err++;
      if (o_rd_req) begin
        if (first_rd < 0) first_rd = cyc;
        if (rd_stall && (o_rd_addr != hold_a || o_rd_sel != hold_s)) stall_err++;
        if (rd_ack) begin
          n_rd++;
          if (q_rd.size() == 0) addr_err++;
          else begin
            ea = q_rd.pop_front(); es = q_sel.pop_front();
            if (o_rd_addr != ea || o_rd_sel != es) addr_err++;
          end
          if (o_load_a != !o_rd_sel || o_load_w != o_rd_sel) strobe_err++;
          rd_stall = 0;
        end else begin
          rd_stall = 1; hold_a = o_rd_addr; hold_s = o_rd_sel;
          if (o_load_a || o_load_w) strobe_err++;
        end
      end else begin
        if (rd_stall) stall_err++;
        rd_stall = 0;
        if (o_load_a || o_load_w) strobe_err++;
      end
      if (o_wr_req) begin
        if (wr_stall && o_wr_addr != hold_w) stall_err++;
        if (wr_ack) begin
          n_wr++;
          last_wr_cyc = cyc;
          if (wr_log_n < 4) begin wr_log[wr_log_n] = o_wr_addr; wr_log_n++; end
          if (q_wr.size() == 0) addr_err++;
          else begin
            ea = q_wr.pop_front();
            if (o_wr_addr != ea) addr_err++;
          end
          if (!o_store) strobe_err++;
          wr_stall = 0;
        end else begin
          wr_stall = 1; hold_w = o_wr_addr;
          if (o_store) strobe_err++;
        end
      end else begin
        if (wr_stall) stall_err++;
        wr_stall = 0;
        if (o_store) strobe_err++;
      end
      if (o_done) begin got_done = 1; done_cyc = cyc; end
    end
    rd_ack = 1'b0; wr_ack = 1'b0; start = 1'b0;
    check($sformatf("v%0d_done_seen", idx), int'(got_done), 1);
    check($sformatf("v%0d_rd_beats", idx), n_rd, v.exp_rd);
    check($sformatf("v%0d_wr_beats", idx), n_wr, v.exp_wr);
    check($sformatf("v%0d_clear_acc", idx), n_clr, v.exp_clr);
    check($sformatf("v%0d_compute_cycles", idx), n_comp, v.exp_comp);
    check($sformatf("v%0d_compute_bursts", idx), n_burst, int'(v.m) * int'(v.n) * int'(v.k));
    check($sformatf("v%0d_addr_errors", idx), addr_err + q_rd.size() + q_wr.size(), 0);
    check($sformatf("v%0d_stall_errors", idx), stall_err, 0);
    check($sformatf("v%0d_strobe_errors", idx), strobe_err, 0);
    check($sformatf("v%0d_latency_clr_rd", idx), first_clr * 10 + first_rd, 12);
    check($sformatf("v%0d_done_after_last_wr", idx), done_cyc - last_wr_cyc, 1);
  endtask

  initial begin
    int bound, nw, act;
    vecs[0] = '{8'd1, 8'd1, 8'd1, 16'h0000, 16'h0200, 16'h0300, 100, 1'b0, 8,  4,  1, 10};
    vecs[1] = '{8'd1, 8'd2, 8'd2, 16'h0100, 16'h0200, 16'h0300, 100, 1'b0, 32, 8,  2, 40};
    vecs[2] = '{8'd1, 8'd2, 8'd2, 16'h0100, 16'h0200, 16'h0300, 30,  1'b0, 32, 8,  2, 40};
    vecs[3] = '{8'd2, 8'd1, 8'd1, 16'h0010, 16'h0020, 16'h0030, 30,  1'b1, 16, 8,  2, 20};
    vecs[4] = '{8'd1, 8'd1, 8'd1, 16'h0000, 16'h0000, 16'hFFFE, 100, 1'b0, 8,  4,  1, 10};
    vecs[5] = '{8'd2, 8'd2, 8'd3, 16'hFFF0, 16'h8000, 16'h4000, 50,  1'b0, 96, 16, 4, 120};

    reset = 1'b1; start = 1'b0; abort = 1'b0; rd_ack = 1'b0; wr_ack = 1'b0;
    cfg_m = '0; cfg_n = '0; cfg_k = '0; cfg_base_a = '0; cfg_base_w = '0; cfg_base_res = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs_zero", int'(any_out), 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_vec(v);
      if (v == 4) begin
        check("wrap_wr0", int'(wr_log[0]), 'hFFFE);
        check("wrap_wr1", int'(wr_log[1]), 'hFFFF);
        check("wrap_wr2", int'(wr_log[2]), 'h0000);
        check("wrap_wr3", int'(wr_log[3]), 'h0001);
      end
    end

    // Zero K tile count: error pulse only, no traffic.
    @(negedge clk);
    cfg_m = 8'd1; cfg_n = 8'd1; cfg_k = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("cfgerr_pulse", int'(o_cfg_err), 1);
    check("cfgerr_not_busy", int'(o_busy | o_rd_req | o_wr_req), 0);
    act = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (any_out) act++;
    end
    check("cfgerr_quiet_after", act, 0);

    // Abort on the third store beat, with an ack in the same cycle.
    @(negedge clk);
    cfg_m = 8'd1; cfg_n = 8'd1; cfg_k = 8'd1;
    cfg_base_a = 16'h0; cfg_base_w = 16'h0200; cfg_base_res = 16'h0300; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rd_ack = 1'b1; wr_ack = 1'b1;
    nw = 0; bound = 0;
    #1;
    while (bound < 200 && !(o_wr_req && nw == 2)) begin
      if (o_wr_req) nw++;
      @(negedge clk); #1;
      bound++;
    end
    check("abort_reached_store_beat2", int'(o_wr_req && nw == 2), 1);
    check("abort_store_beat2_addr", int'(o_wr_addr), 'h0302);
    abort = 1'b1;
    #1;
    check("abort_overrides_ack", int'(o_store), 0);
    @(negedge clk);
    abort = 1'b0; rd_ack = 1'b0; wr_ack = 1'b0;
    #1;
    check("abort_outputs_zero", int'(any_out), 0);
    act = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (any_out) act++;
    end
    check("abort_no_done", act, 0);
    run_vec(0);

    // Reset while loading W rows.
    @(negedge clk);
    cfg_m = 8'd1; cfg_n = 8'd2; cfg_k = 8'd2;
    cfg_base_a = 16'h0100; cfg_base_w = 16'h0200; cfg_base_res = 16'h0300; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rd_ack = 1'b1; wr_ack = 1'b1;
    bound = 0;
    #1;
    while (bound < 200 && !(o_rd_req && o_rd_sel)) begin
      @(negedge clk); #1;
      bound++;
    end
    check("reset_reached_load_w", int'(o_rd_req && o_rd_sel), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; rd_ack = 1'b0; wr_ack = 1'b0;
    #1;
    check("reset_midrun_outputs_zero", int'(any_out), 0);
    run_vec(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
